board_step_ctrl: RTL and testbench

Board-level execution controller between the FPGA pins and the processor `top`. It synchronises the push button, mode switch and selector switches, and debounces the button. It generates a single clock-enable `cpu_en` for the processor: free-run, single-step, or N-cycle burst per press. It also multiplexes a processor status word onto the LEDs. It replaces the fixed run/step behaviour with parametrised widths, a debounce length and a burst mode.

---
 rtl/board_step_ctrl.sv | 148 ++++++++++++++
 tb/tb_board_step_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_step_ctrl.sv
// Board execution controller: synchronises and debounces the front-panel controls and
// gates the processor with a free-run, single-step or burst clock-enable.
module board_step_ctrl #(
  parameter int unsigned SW_W        = 3,
  parameter int unsigned LED_W       = 8,
  parameter int unsigned DISP_W      = 32,
  parameter int unsigned DBNC_CYCLES = 16,
  parameter int unsigned BURST_LEN   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              ena_switch,
  input  logic              burst_mode,
  input  logic [SW_W-1:0]   Switches,
  input  logic [DISP_W-1:0] disp_word,
  output logic              cpu_en,
  output logic [SW_W-1:0]   sw_sync,
  output logic [LED_W-1:0]  LEDs,
  output logic [15:0]       step_count
);

  localparam int unsigned NSL   = DISP_W / LED_W;
  localparam int unsigned CNT_W = (DBNC_CYCLES > 2) ? $clog2(DBNC_CYCLES) : 1;
  localparam int unsigned REM_W = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {StIdle, StRun, StBurst} state_e;

  state_e             state;
  logic [REM_W-1:0]   remaining;
  logic [2:0]         ctl_meta;
  logic [2:0]         ctl_sync;
  logic [SW_W-1:0]    sw_meta;
  logic               push_s;
  logic               mode_s;
  logic               burst_s;
  logic               push_db;
  logic               push_db_d;
  logic [CNT_W-1:0]   cnt;
  logic               press;
  logic [DISP_W-1:0]  disp_shift;
  logic [LED_W-1:0]   led_next;

  // Control bits travel together as {burst_mode, ena_switch, push}.
  assign {burst_s, mode_s, push_s} = ctl_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_meta <= '0;
      ctl_sync <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      ctl_meta <= {burst_mode, ena_switch, push};
      ctl_sync <= ctl_meta;
      sw_meta  <= Switches;
      sw_sync  <= sw_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_db   <= 1'b0;
      push_db_d <= 1'b0;
      cnt       <= '0;
    end else begin
      push_db_d <= push_db;
      if (push_s != push_db) begin
        if (cnt == CNT_W'(DBNC_CYCLES - 1)) begin
          push_db <= push_s;
          cnt     <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = push_db & ~push_db_d;

  // cpu_en is registered alongside the state so it is high exactly in RUN and BURST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      remaining <= '0;
      cpu_en    <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (!mode_s) begin
            state  <= StRun;
            cpu_en <= 1'b1;
          end else if (press) begin
            state     <= StBurst;
            cpu_en    <= 1'b1;
            remaining <= burst_s ? REM_W'(BURST_LEN) : REM_W'(1);
          end
        end
        StRun: begin
          if (mode_s) begin
            state  <= StIdle;
            cpu_en <= 1'b0;
          end
        end
        StBurst: begin
          remaining <= remaining - REM_W'(1);
          if (!mode_s) begin
            state <= StRun;
          end else if (remaining == REM_W'(1)) begin
            state  <= StIdle;
            cpu_en <= 1'b0;
          end
        end
        default: begin
          state  <= StIdle;
          cpu_en <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_count <= '0;
    end else if (cpu_en) begin
      step_count <= step_count + 16'd1;
    end
  end

  always_comb begin
    disp_shift = disp_word >> (32'(sw_sync) * LED_W);
    led_next   = '0;
    if (32'(sw_sync) < NSL) begin
      led_next = disp_shift[LED_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      LEDs <= '0;
    end else begin
      LEDs <= led_next;
    end
  end

endmodule

// File: tb/tb_board_step_ctrl.sv
// Bench for board_step_ctrl: behavioural model checked every cycle, directed scenarios with
// hand-computed expectations, then randomized control/button activity.
module tb_board_step_ctrl;

  localparam int DB     = 4;
  localparam int BL     = 4;
  localparam int SW_W   = 3;
  localparam int LED_W  = 8;
  localparam int DISP_W = 32;
  localparam int NSL    = DISP_W / LED_W;

  logic              clk;
  logic              reset;
  logic              push;
  logic              ena_switch;
  logic              burst_mode;
  logic [SW_W-1:0]   Switches;
  logic [DISP_W-1:0] disp_word;
  logic              cpu_en;
  logic [SW_W-1:0]   sw_sync;
  logic [LED_W-1:0]  LEDs;
  logic [15:0]       step_count;

  board_step_ctrl #(
    .SW_W       (SW_W),
    .LED_W      (LED_W),
    .DISP_W     (DISP_W),
    .DBNC_CYCLES(DB),
    .BURST_LEN  (BL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .ena_switch(ena_switch),
    .burst_mode(burst_mode),
    .Switches  (Switches),
    .disp_word (disp_word),
    .cpu_en    (cpu_en),
    .sw_sync   (sw_sync),
    .LEDs      (LEDs),
    .step_count(step_count)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Reference model: raw inputs pass through two-sample delay lines, the button is accepted
  // after DB consecutive disagreeing samples, and the controller owes some number of enables.
  localparam int M_IDLE = 0, M_RUN = 1, M_BURST = 2;
  int        m_p1, m_ps, m_e1, m_es, m_b1, m_bs, m_s1, m_sw;
  int        m_acc, m_acc_prev, m_run_len, m_mode, m_owed;
  bit        m_press;
  bit [15:0] m_count;
  bit [7:0]  m_leds;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_p1 = 0; m_ps = 0; m_e1 = 0; m_es = 0; m_b1 = 0; m_bs = 0; m_s1 = 0; m_sw = 0;
      m_acc = 0; m_acc_prev = 0; m_run_len = 0; m_mode = M_IDLE; m_owed = 0;
      m_count = 0; m_leds = 0;
    end else begin
      m_press = (m_acc == 1) && (m_acc_prev == 0);
      if (m_mode != M_IDLE) m_count = m_count + 16'd1;
      m_leds = (m_sw < NSL) ? 8'(disp_word >> (m_sw * LED_W)) : 8'h00;
      if (m_mode == M_IDLE) begin
        if (m_es == 0) m_mode = M_RUN;
        else if (m_press) begin
          m_mode = M_BURST;
          m_owed = (m_bs != 0) ? BL : 1;
        end
      end else if (m_mode == M_RUN) begin
        if (m_es == 1) m_mode = M_IDLE;
      end else begin
        m_owed = m_owed - 1;
        if (m_es == 0) m_mode = M_RUN;
        else if (m_owed == 0) m_mode = M_IDLE;
      end
      m_acc_prev = m_acc;
      if (m_ps != m_acc) begin
        m_run_len = m_run_len + 1;
        if (m_run_len == DB) begin
          m_acc     = m_ps;
          m_run_len = 0;
        end
      end else begin
        m_run_len = 0;
      end
      m_ps = m_p1; m_p1 = int'(push);
      m_es = m_e1; m_e1 = int'(ena_switch);
      m_bs = m_b1; m_b1 = int'(burst_mode);
      m_sw = m_s1; m_s1 = int'(Switches);
    end
  end

  int n_cmp;
  int n_bad;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_en) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] mask;
    int          cnt_en;
    int          hold;
    bit          ok;
    logic [15:0] base;

    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1; push = 1'b0; ena_switch = 1'b0; burst_mode = 1'b0;
    Switches = '0; disp_word = '0;

    fork
      forever begin
        @(negedge clk);
        n_cmp++;
        if (cpu_en !== (m_mode != M_IDLE) || sw_sync !== 3'(m_sw) || LEDs !== m_leds ||
            step_count !== m_count) begin
          n_bad++;
          $display("FAIL model_cmp t=%0t cpu_en=%0b/%0b sw_sync=%0d/%0d LEDs=%0h/%0h cnt=%0h/%0h",
                   $time, cpu_en, (m_mode != M_IDLE), sw_sync, m_sw, LEDs, m_leds,
                   step_count, m_count);
        end
      end
    join_none

    // Reset and free-run
    #5;
    check("rst_cpu_en", cpu_en, 0);
    check("rst_step_count", step_count, 0);
    #17 reset = 1'b0;
    @(negedge clk);
    check("freerun_en", cpu_en, 1);
    check("freerun_cnt0", step_count, 0);
    @(negedge clk);
    check("freerun_cnt1", step_count, 1);
    @(negedge clk);
    check("freerun_cnt2", step_count, 2);

    // Single step
    ena_switch = 1'b1;
    repeat (6) @(negedge clk);
    base = step_count;
    mask = '0;
    push = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      mask[i] = cpu_en;
      if (i == 10) push = 1'b0;
    end
    check("single_step_mask", mask, 32'h80);
    check("single_step_delta", 16'(step_count - base), 1);

    // Bounce shorter than the debounce window
    burst_mode = 1'b1;
    repeat (4) @(negedge clk);
    base   = step_count;
    cnt_en = 0;
    for (int i = 0; i < 12; i++) begin
      push = ((i / 2) % 2 == 0);
      @(negedge clk);
      cnt_en += int'(cpu_en);
    end
    push = 1'b0;
    repeat (10) begin
      @(negedge clk);
      cnt_en += int'(cpu_en);
    end
    check("bounce_no_enable", cnt_en, 0);
    check("bounce_delta", 16'(step_count - base), 0);

    // Stable press in burst mode
    mask = '0;
    push = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      mask[i] = cpu_en;
      if (i == 12) push = 1'b0;
    end
    check("burst_mask", mask, 32'h780);
    repeat (10) @(negedge clk);

    // LED select
    disp_word = 32'hA1B2C3D4;
    Switches  = 3'd1;
    repeat (3) @(negedge clk);
    check("led_sel1_sw", sw_sync, 1);
    check("led_sel1", LEDs, 8'hC3);
    Switches = 3'd3;
    repeat (2) @(negedge clk);
    check("led_sel3_early", LEDs, 8'hC3);
    @(negedge clk);
    check("led_sel3", LEDs, 8'hA1);
    disp_word = 32'h11223344;
    @(negedge clk);
    check("led_disp_latency", LEDs, 8'h11);
    disp_word = 32'hA1B2C3D4;
    Switches  = 3'd5;
    repeat (3) @(negedge clk);
    check("led_sel5", LEDs, 8'h00);

    // Mode change mid-burst
    push = 1'b1;
    wait_en(ok);
    check("midburst_start", ok, 1);
    ena_switch = 1'b0;
    cnt_en = 0;
    repeat (12) begin
      @(negedge clk);
      cnt_en += int'(cpu_en);
    end
    check("midburst_to_run", cnt_en, 12);
    push = 1'b0;

    // step_count wrap
    @(negedge clk);
    #1 reset = 1'b1;
    #3 reset = 1'b0;
    repeat (65536) @(negedge clk);
    check("wrap_ffff", step_count, 16'hFFFF);
    @(negedge clk);
    check("wrap_zero", step_count, 0);
    check("wrap_en", cpu_en, 1);

    // Reset in the middle of a burst, button still held afterwards
    ena_switch = 1'b1;
    burst_mode = 1'b1;
    repeat (6) @(negedge clk);
    push = 1'b1;
    wait_en(ok);
    check("rstburst_start", ok, 1);
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("rstburst_cpu_en", cpu_en, 0);
    check("rstburst_leds", LEDs, 0);
    check("rstburst_sw", sw_sync, 0);
    check("rstburst_cnt", step_count, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (24) @(negedge clk);
    push = 1'b0;
    repeat (10) @(negedge clk);

    // Randomized activity
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      if (hold == 0) begin
        push = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 10);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 99) < 3) ena_switch = ~ena_switch;
      if ($urandom_range(0, 99) < 5) burst_mode = ~burst_mode;
      if ($urandom_range(0, 99) < 10) Switches = 3'($urandom);
      disp_word = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        #2 reset = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
